// File: rtl/debug_breakpoint_unit.sv
// 80386-style debug register set DR0-DR3/DR6/DR7 with address breakpoint
// matching, sticky status and a registered debug trap pulse.
module debug_breakpoint_unit #(
   parameter int NUM_BP     = 4,
   parameter int ADDR_WIDTH = 32
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  write_enable,
   input  logic                  read_enable,
   input  logic [2:0]            write_index,
   input  logic [2:0]            read_index,
   input  logic [31:0]           write_data,
   output logic [31:0]           read_data,
   input  logic                  access_valid,
   input  logic [ADDR_WIDTH-1:0] access_address,
   input  logic [1:0]            access_type,
   input  logic [1:0]            access_length,
   input  logic                  single_step,
   input  logic                  instruction_retire,
   input  logic                  task_switch,
   input  logic                  task_trap,
   output logic                  debug_trap,
   output logic                  gd_fault
);

   function automatic logic [31:0] f_dr7_mask();
      logic [31:0] m;
      m = 32'h0000_2000;
      for (int i = 0; i < NUM_BP; i++) begin
         m[2*i +: 2]    = 2'b11;
         m[16+4*i +: 4] = 4'hF;
      end
      return m;
   endfunction

   function automatic logic [31:0] f_l_mask();
      logic [31:0] m;
      m = '0;
      for (int i = 0; i < NUM_BP; i++)
         m[2*i] = 1'b1;
      return m;
   endfunction

   function automatic logic [ADDR_WIDTH-1:0] win_mask(input logic [1:0] len);
      logic [ADDR_WIDTH-1:0] m;
      unique case (len)
         2'b00:   m = '0;
         2'b01:   m = ADDR_WIDTH'(1);
         default: m = ADDR_WIDTH'(3);
      endcase
      return m;
   endfunction

   localparam logic [31:0] DR7_MASK = f_dr7_mask();
   localparam logic [31:0] L_MASK   = f_l_mask();
   localparam logic [31:0] DR6_MASK =
      32'h0000_E000 | ((32'd1 << NUM_BP) - 32'd1);

   logic [ADDR_WIDTH-1:0] bp_q [NUM_BP];
   logic [31:0]           dr6_q;
   logic [31:0]           dr7_q;

   logic [NUM_BP-1:0]     hit;
   logic                  gd_block;
   logic                  wr_ok;
   logic                  ss_event;
   logic                  tt_event;
   logic [31:0]           ev;
   logic [31:0]           dr6_next;
   logic [31:0]           dr7_next;

   always_comb begin
      read_data = '0;
      for (int i = 0; i < NUM_BP; i++)
         if (read_index == 3'(i))
            read_data[ADDR_WIDTH-1:0] = bp_q[i];
      if (read_index == 3'd6)
         read_data = dr6_q;
      if (read_index == 3'd7)
         read_data = dr7_q;
   end

   // Both sides are masked by the wider window, so any overlap hits.
   always_comb begin
      logic [1:0]            rw;
      logic [1:0]            len;
      logic                  type_ok;
      logic [ADDR_WIDTH-1:0] keep;
      hit     = '0;
      rw      = '0;
      len     = '0;
      type_ok = 1'b0;
      keep    = '0;
      for (int i = 0; i < NUM_BP; i++) begin
         rw  = dr7_q[16+4*i +: 2];
         len = dr7_q[18+4*i +: 2];
         unique case (rw)
            2'b00:   type_ok = (access_type == 2'b00) && (len == 2'b00);
            2'b01:   type_ok = (access_type == 2'b01);
            2'b11:   type_ok = (access_type == 2'b01) ||
                               (access_type == 2'b11);
            default: type_ok = 1'b0;
         endcase
         keep   = ~(win_mask(len) | win_mask(access_length));
         hit[i] = access_valid
                & (dr7_q[2*i] | dr7_q[2*i+1])
                & type_ok
                & ((bp_q[i] & keep) == (access_address & keep));
      end
   end

   always_comb begin
      gd_block = dr7_q[13] & (write_enable | read_enable);
      wr_ok    = write_enable & ~gd_block;
      ss_event = instruction_retire & single_step;
      tt_event = task_switch & task_trap;

      ev               = '0;
      ev[NUM_BP-1:0]   = hit;
      ev[13]           = gd_block;
      ev[14]           = ss_event;
      ev[15]           = tt_event;

      if (wr_ok && write_index == 3'd6)
         dr6_next = (write_data & DR6_MASK) | ev;
      else
         dr6_next = dr6_q | ev;

      if (wr_ok && write_index == 3'd7)
         dr7_next = write_data & DR7_MASK;
      else
         dr7_next = dr7_q;
      if (gd_block)
         dr7_next[13] = 1'b0;
      if (task_switch)
         dr7_next = dr7_next & ~L_MASK;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_BP; i++)
            bp_q[i] <= '0;
         dr6_q      <= '0;
         dr7_q      <= '0;
         debug_trap <= 1'b0;
         gd_fault   <= 1'b0;
      end else begin
         for (int i = 0; i < NUM_BP; i++)
            if (wr_ok && write_index == 3'(i))
               bp_q[i] <= write_data[ADDR_WIDTH-1:0];
         dr6_q      <= dr6_next;
         dr7_q      <= dr7_next;
         debug_trap <= (|hit) | ss_event | tt_event;
         gd_fault   <= gd_block;
      end
   end

endmodule

// File: tb/tb_debug_breakpoint_unit.sv
// Bench for debug_breakpoint_unit: directed scenarios plus randomized
// traffic against a field-level model of the debug registers.
module tb_debug_breakpoint_unit;

   localparam int NBP = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        write_enable = 1'b0;
   logic        read_enable = 1'b0;
   logic [2:0]  write_index = '0;
   logic [2:0]  read_index = '0;
   logic [31:0] write_data = '0;
   logic [31:0] read_data;
   logic        access_valid = 1'b0;
   logic [31:0] access_address = '0;
   logic [1:0]  access_type = '0;
   logic [1:0]  access_length = '0;
   logic        single_step = 1'b0;
   logic        instruction_retire = 1'b0;
   logic        task_switch = 1'b0;
   logic        task_trap = 1'b0;
   logic        debug_trap;
   logic        gd_fault;

   int vec = 0;
   int bad = 0;

   debug_breakpoint_unit #(.NUM_BP(NBP), .ADDR_WIDTH(32)) dut (
      .clock(clock), .reset(reset),
      .write_enable(write_enable), .read_enable(read_enable),
      .write_index(write_index), .read_index(read_index),
      .write_data(write_data), .read_data(read_data),
      .access_valid(access_valid), .access_address(access_address),
      .access_type(access_type), .access_length(access_length),
      .single_step(single_step), .instruction_retire(instruction_retire),
      .task_switch(task_switch), .task_trap(task_trap),
      .debug_trap(debug_trap), .gd_fault(gd_fault)
   );

   always #5 clock = ~clock;

   // Reference model: named register fields.
   logic [31:0] m_bp [NBP];
   bit          m_b [NBP];
   bit          m_l [NBP];
   bit          m_g [NBP];
   logic [1:0]  m_rw [NBP];
   logic [1:0]  m_len [NBP];
   bit          m_bd, m_bs, m_bt, m_gd;
   bit          m_trap, m_gdf;

   function automatic int span(input logic [1:0] l);
      return (l == 2'b00) ? 1 : (l == 2'b01) ? 2 : 4;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NBP; i++) begin
         m_bp[i] = 0; m_b[i] = 0; m_l[i] = 0; m_g[i] = 0;
         m_rw[i] = 0; m_len[i] = 0;
      end
      m_bd = 0; m_bs = 0; m_bt = 0; m_gd = 0;
      m_trap = 0; m_gdf = 0;
   endtask

   function automatic logic [31:0] m_read(input logic [2:0] idx);
      logic [31:0] v;
      v = 0;
      if (idx < 3'(NBP)) v = m_bp[idx[1:0]];
      else if (idx == 3'd6) begin
         for (int i = 0; i < NBP; i++) v[i] = m_b[i];
         v[13] = m_bd; v[14] = m_bs; v[15] = m_bt;
      end else if (idx == 3'd7) begin
         for (int i = 0; i < NBP; i++) begin
            v[2*i] = m_l[i]; v[2*i+1] = m_g[i];
            v[16+4*i +: 2] = m_rw[i]; v[18+4*i +: 2] = m_len[i];
         end
         v[13] = m_gd;
      end
      return v;
   endfunction

   task automatic model_step();
      bit gdblk, any, tok, bs, bt;
      bit h [NBP];
      int w;
      gdblk = m_gd && (write_enable || read_enable);
      bs = instruction_retire && single_step;
      bt = task_switch && task_trap;
      any = 0;
      for (int i = 0; i < NBP; i++) begin
         tok = (m_rw[i] == 0 && access_type == 0 && m_len[i] == 0) ||
               (m_rw[i] == 1 && access_type == 1) ||
               (m_rw[i] == 3 && (access_type == 1 || access_type == 3));
         w = span(m_len[i]);
         if (span(access_length) > w) w = span(access_length);
         h[i] = access_valid && (m_l[i] || m_g[i]) && tok &&
                (access_address / 32'(w) == m_bp[i] / 32'(w));
         any = any || h[i];
      end
      if (write_enable && !gdblk) begin
         if (write_index < 3'(NBP)) m_bp[write_index[1:0]] = write_data;
         else if (write_index == 3'd6) begin
            for (int i = 0; i < NBP; i++) m_b[i] = write_data[i];
            m_bd = write_data[13]; m_bs = write_data[14];
            m_bt = write_data[15];
         end else if (write_index == 3'd7) begin
            for (int i = 0; i < NBP; i++) begin
               m_l[i] = write_data[2*i]; m_g[i] = write_data[2*i+1];
               m_rw[i] = write_data[16+4*i +: 2];
               m_len[i] = write_data[18+4*i +: 2];
            end
            m_gd = write_data[13];
         end
      end
      for (int i = 0; i < NBP; i++) if (h[i]) m_b[i] = 1;
      if (bs) m_bs = 1;
      if (bt) m_bt = 1;
      if (gdblk) begin m_gd = 0; m_bd = 1; end
      if (task_switch) for (int i = 0; i < NBP; i++) m_l[i] = 0;
      m_trap = any || bs || bt;
      m_gdf = gdblk;
   endtask

   task automatic idle();
      write_enable = 0; read_enable = 0; access_valid = 0;
      single_step = 0; instruction_retire = 0;
      task_switch = 0; task_trap = 0;
   endtask

   task automatic tick();
      model_step();
      @(posedge clock);
      #1;
   endtask

   task automatic wr(input logic [2:0] idx, input logic [31:0] d);
      write_enable = 1; write_index = idx; write_data = d;
      tick();
      write_enable = 0;
   endtask

   task automatic chk_rd(input string nm, input logic [2:0] idx,
                         input logic [31:0] exp);
      read_index = idx;
      #1;
      vec++;
      if (read_data !== exp) begin
         bad++;
         $display("FAIL %s: read_data[%0d]=%h expected %h", nm, idx,
                  read_data, exp);
      end
   endtask

   task automatic chk_bit(input string nm, input logic got, input logic exp);
      vec++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %b expected %b", nm, got, exp);
      end
   endtask

   task automatic access(input logic [31:0] a, input logic [1:0] t,
                         input logic [1:0] l);
      access_valid = 1; access_address = a;
      access_type = t; access_length = l;
   endtask

   task automatic test_reset();
      chk_bit("reset_trap", debug_trap, 1'b0);
      chk_bit("reset_gd", gd_fault, 1'b0);
      #12 reset = 0;
      model_reset();
      for (int i = 0; i < 8; i++) chk_rd("reset_reg", 3'(i), 32'h0);
   endtask

   task automatic test_regs();
      wr(0, 32'h1234_5678);
      chk_rd("dr0_write", 0, 32'h1234_5678);
      wr(4, 32'hDEAD_BEEF);
      chk_rd("reserved4", 4, 32'h0);
      wr(7, 32'hFFFF_DFFF);
      chk_rd("dr7_mask", 7, 32'hFFFF_00FF);
      wr(7, 32'h0);
   endtask

   task automatic test_data_bp();
      wr(0, 32'h0000_1000);
      wr(7, 32'h0003_0001);
      access(32'h1000, 2'b11, 2'b00);
      tick();
      access_valid = 0;
      chk_bit("bp0_trap", debug_trap, 1'b1);
      chk_rd("bp0_dr6", 6, 32'h1);
      tick();
      chk_bit("bp0_one_pulse", debug_trap, 1'b0);
      wr(6, 0);
      access(32'h1001, 2'b11, 2'b00);
      tick();
      access_valid = 0;
      chk_bit("bp0_miss", debug_trap, 1'b0);
   endtask

   task automatic test_len_window();
      wr(1, 32'h0000_2004);
      wr(7, 32'h00D0_0008);
      wr(6, 0);
      access(32'h2006, 2'b01, 2'b01);
      tick();
      access_valid = 0;
      chk_bit("len_hit", debug_trap, 1'b1);
      chk_rd("len_dr6", 6, 32'h2);
      wr(6, 0);
      access(32'h2006, 2'b11, 2'b01);
      tick();
      chk_bit("rw_miss", debug_trap, 1'b0);
      access(32'h2008, 2'b01, 2'b11);
      tick();
      access_valid = 0;
      chk_bit("win_miss", debug_trap, 1'b0);
      chk_rd("len_dr6_clear", 6, 32'h0);
   endtask

   task automatic test_gd();
      wr(7, 32'h0000_2000);
      chk_rd("gd_set", 7, 32'h2000);
      write_enable = 1; write_index = 0; write_data = 32'hFFFF_FFFF;
      tick();
      chk_bit("gd_fault", gd_fault, 1'b1);
      chk_bit("gd_no_trap", debug_trap, 1'b0);
      chk_rd("gd_dr0_kept", 0, 32'h0000_1000);
      chk_rd("gd_bd", 6, 32'h2000);
      chk_rd("gd_cleared", 7, 32'h0);
      write_data = 32'h0000_55AA;
      tick();
      write_enable = 0;
      chk_bit("gd_fault_once", gd_fault, 1'b0);
      chk_rd("gd_next_write", 0, 32'h0000_55AA);
   endtask

   task automatic test_step_task();
      wr(6, 0);
      wr(7, 32'h0000_0039);
      single_step = 1; instruction_retire = 1;
      task_switch = 1; task_trap = 1;
      tick();
      idle();
      chk_bit("st_trap", debug_trap, 1'b1);
      chk_rd("st_dr6", 6, 32'h0000_C000);
      chk_rd("st_l_clear", 7, 32'h0000_0028);
      tick();
      chk_bit("st_one_pulse", debug_trap, 1'b0);
   endtask

   task automatic test_back_to_back();
      wr(0, 32'h0000_1000);
      wr(7, 32'h0003_0001);
      wr(6, 32'h0000_E00F);
      chk_rd("b2b_dr6_pre", 6, 32'h0000_E00F);
      write_enable = 1; write_index = 6; write_data = 0;
      access(32'h1000, 2'b11, 2'b00);
      tick();
      write_enable = 0;
      chk_bit("coll_trap", debug_trap, 1'b1);
      chk_rd("coll_dr6", 6, 32'h1);
      tick();
      chk_bit("b2b_trap", debug_trap, 1'b1);
      access_valid = 0;
      tick();
      chk_bit("b2b_end", debug_trap, 1'b0);
   endtask

   task automatic test_reset_mid();
      access(32'h1000, 2'b11, 2'b00);
      tick();
      access_valid = 0;
      chk_bit("pend_trap", debug_trap, 1'b1);
      reset = 1;
      model_reset();
      #1;
      chk_bit("rst_trap", debug_trap, 1'b0);
      chk_bit("rst_gd", gd_fault, 1'b0);
      for (int i = 0; i < 8; i++) chk_rd("rst_reg", 3'(i), 32'h0);
      reset = 0;
   endtask

   task automatic test_random();
      for (int n = 0; n < 3000; n++) begin
         write_enable = ($urandom_range(0, 3) == 0);
         write_index = 3'($urandom_range(0, 7));
         if (write_index < 3'(NBP))
            write_data = 32'($urandom_range(0, 63));
         else if (write_index == 3'd7)
            write_data = ($urandom & ~32'h2000) |
                         (($urandom_range(0, 15) == 0) ? 32'h2000 : 32'h0);
         else
            write_data = $urandom;
         read_enable = ($urandom_range(0, 7) == 0);
         read_index = 3'($urandom_range(0, 7));
         access_valid = 1'($urandom_range(0, 1));
         access_address = 32'($urandom_range(0, 63));
         access_type = 2'($urandom_range(0, 3));
         access_length = 2'($urandom_range(0, 3));
         single_step = 1'($urandom_range(0, 1));
         instruction_retire = ($urandom_range(0, 7) == 0);
         task_switch = ($urandom_range(0, 15) == 0);
         task_trap = 1'($urandom_range(0, 1));
         #1;
         vec++;
         if (read_data !== m_read(read_index)) begin
            bad++;
            $display("FAIL rnd_read: cycle %0d idx %0d got %h expected %h",
                     n, read_index, read_data, m_read(read_index));
         end
         tick();
         vec++;
         if (debug_trap !== m_trap) begin
            bad++;
            $display("FAIL rnd_trap: cycle %0d got %b expected %b",
                     n, debug_trap, m_trap);
         end
         vec++;
         if (gd_fault !== m_gdf) begin
            bad++;
            $display("FAIL rnd_gd: cycle %0d got %b expected %b",
                     n, gd_fault, m_gdf);
         end
      end
      idle();
   endtask

   initial begin
      model_reset();
      test_reset();
      test_regs();
      test_data_bp();
      test_len_window();
      test_gd();
      test_step_task();
      test_back_to_back();
      test_reset_mid();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vec, bad);
      $finish;
   end

endmodule

// File: doc/debug_breakpoint_unit.md
# debug_breakpoint_unit

Parametrised successor to the plain debug register file: holds the 80386 debug register set (breakpoint addresses DR0–DR3, status DR6, control DR7), compares every bus/fetch access against the enabled breakpoints, maintains sticky status bits and raises a registered debug trap toward the exception unit. It sits in the register-file cluster, fed by the MOV DRn path on the write side and by the linear-address stage of the bus/prefetch units on the match side.

## Interface
- NUM_BP, 4, number of implemented breakpoint address registers (1–4)
- ADDR_WIDTH, 32, linear address width compared against breakpoints
- clock  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- write_enable  input  1  MOV DRn,reg request this cycle
- read_enable  input  1  MOV reg,DRn request this cycle (GD detection only)
- write_index / read_index  input  3  debug register index
- write_data  input  32  data for write_index
- read_data  output  32  combinational contents of read_index
- access_valid  input  1  linear access presented this cycle
- access_address  input  ADDR_WIDTH  linear address of access
- access_type  input  2  00 instruction fetch, 01 data write, 11 data read
- access_length  input  2  00 byte, 01 word, 11 dword
- single_step  input  1  EFLAGS.TF sampled at instruction_retire
- instruction_retire  input  1  one instruction completed this cycle
- task_switch  input  1  task switch completed this cycle
- task_trap  input  1  T bit of incoming TSS, valid with task_switch
- debug_trap  output  1  one-cycle pulse: new trap-class debug event
- gd_fault  output  1  one-cycle pulse: DR access blocked by GD

## Operation
- Register map: index i < NUM_BP → breakpoint address DRi (low ADDR_WIDTH bits stored, upper read 0); NUM_BP..5 → reserved, read 0, writes ignored; 6 → DR6; 7 → DR7.
- DR7 fields: L[i]=bit 2i, G[i]=bit 2i+1, GD=bit 13, RW[i]=bits 17+4i:16+4i, LEN[i]=bits 19+4i:18+4i. Fields for i ≥ NUM_BP and all other bits read 0.
- DR6 fields: B[i]=bit i (i<NUM_BP), BD=13, BS=14, BT=15; all other bits read 0. All DR6 bits sticky; cleared only by software write or reset.
- Breakpoint i matches when access_valid, (L[i]|G[i]), and RW/type agree: RW 00 ↔ type 00, RW 01 ↔ type 01, RW 11 ↔ type 01 or 11; RW 10 never matches.
- Address compare masks low bits by LEN[i]: 00 none, 01 bit 0, 11 bits 1:0, 10 treated as 11. Hit when masked DRi equals access_address masked by the wider of LEN[i] and access_length mask (overlap within aligned window).
- Instruction-fetch breakpoints additionally require LEN[i]=00; otherwise no match.
- Single step: instruction_retire & single_step sets BS. Task trap: task_switch & task_trap sets BT.
- Task switch clears all L[i] bits (G bits kept) on the same edge.
- General detect: if GD=1 and (write_enable|read_enable) targets any index, the write is suppressed, BD is set, GD is cleared, gd_fault pulses. debug_trap is not raised for BD.
- Simultaneous events OR together into DR6. Software write to DR6 coinciding with set events: DR6 ← write_data | new event bits.

## Timing
- Reset: all DRi, DR6, DR7 = 0; debug_trap = 0; gd_fault = 0.
- Writes take effect on the next rising edge; read_data reflects them the following cycle (no write-to-read bypass).
- Match uses DR0–DR3/DR7 values before the current edge; a DR7 write and an access in the same cycle compare against the old DR7.
- Event at cycle N: DR6 bit set and debug_trap high during cycle N+1, for exactly one cycle per event cycle; back-to-back event cycles give back-to-back pulses.
- gd_fault high in cycle N+1 for a blocked access in cycle N; a second DR access in cycle N+1 proceeds (GD already 0).
- Reset asserted mid-event cancels any pending pulse; outputs go 0 immediately.

## Test plan
- Reset, read indices 0–7 → all 0; write DR0=0x1234_5678, read idx 0 next cycle → 0x1234_5678; write idx 4 → read 0.
- DR0=0x1000, DR7=0x0003_0001 (L0, RW=11, LEN=00); data read 0x1000 byte → DR6=0x0000_0001, debug_trap one pulse at N+1; read 0x1001 → no trap.
- DR1=0x2004, LEN=11 RW=01 G1; word write 0x2006 → B1 set; read access 0x2006 → no hit; dword write 0x2008 → no hit.
- DR7 GD=1; write_enable idx 0 with 0xFFFF_FFFF → DR0 unchanged, DR6 BD set, gd_fault pulse, DR7 bit 13 reads 0; next write succeeds.
- single_step & instruction_retire together with task_switch & task_trap → DR6=0x0000_C000, single debug_trap pulse; task_switch clears L bits, G bits unchanged.
- Write DR6=0 in same cycle as B0 hit → DR6 reads 0x0000_0001; assert reset during pending trap → debug_trap stays 0, all registers 0.
